// File: rtl/matmul_pkg.sv
// Shared widths and sequencer state encoding for the matrix-multiply controller.
package matmul_pkg;

    localparam int MM_DW = 32;
    localparam int MM_OW = 16;
    localparam int MM_AW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        WAIT_A = 3'd2,
        RD_B   = 3'd3,
        WAIT_B = 3'd4,
        MAC    = 3'd5,
        WR_C   = 3'd6,
        DONE   = 3'd7
    } matmul_state_t;

endpackage

// File: rtl/matmul_mac.sv
// Operand capture registers plus a single multiply-accumulate stage.
module matmul_mac #(
    parameter int DW = 32,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          a_en,
    input  logic          b_en,
    input  logic          mac_en,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] acc
);

    logic [OW-1:0]   a;
    logic [OW-1:0]   b;
    logic [2*OW-1:0] prod;
    logic            unused_rdata;

    // Operands are unsigned; upper read-word bits carry no meaning here.
    assign prod         = {{OW{1'b0}}, a} * {{OW{1'b0}}, b};
    assign unused_rdata = ^rdata[DW-1:OW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            acc <= '0;
        end else begin
            if (a_en) a <= rdata[OW-1:0];
            if (b_en) b <= rdata[OW-1:0];
            if (clr)
                acc <= '0;
            else if (mac_en)
                acc <= acc + DW'(prod);
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer computing C = A x B through a single-port word-addressed memory,
// one access at a time, pulsing end_o when the last C element is written.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DW = MM_DW,
    parameter int OW = MM_OW,
    parameter int AW = MM_AW
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic [AW-1:0] matrix_a_addr_i,
    input  logic [AW-1:0] matrix_b_addr_i,
    input  logic [AW-1:0] matrix_c_addr_i,
    input  logic [15:0]   m_i,
    input  logic [15:0]   n_i,
    input  logic [15:0]   p_i,
    input  logic          start_i,
    output logic          end_o,
    output logic          busy_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i
);

    matmul_state_t state, nxt;
    logic          start_q;
    logic [AW-1:0] a_base, b_base, c_base;
    logic [15:0]   m_q, n_q, p_q;
    logic [15:0]   i, j, k;
    logic [DW-1:0] acc;
    logic          launch, zero_dim;
    logic          i_last, j_last, k_last, wr_done;
    logic [31:0]   a_lin, b_lin, c_lin;
    logic          unused_lin;

    assign launch   = (state == IDLE) && start_i && !start_q;
    assign zero_dim = (m_i == 16'd0) || (n_i == 16'd0) || (p_i == 16'd0);
    assign i_last   = (i == m_q - 16'd1);
    assign j_last   = (j == p_q - 16'd1);
    assign k_last   = (k == n_q - 16'd1);
    assign wr_done  = (state == WR_C) && mem_gnt_i;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (launch) nxt = zero_dim ? DONE : RD_A;
            RD_A:    if (mem_gnt_i) nxt = WAIT_A;
            WAIT_A:  if (mem_rvalid_i) nxt = RD_B;
            RD_B:    if (mem_gnt_i) nxt = WAIT_B;
            WAIT_B:  if (mem_rvalid_i) nxt = MAC;
            MAC:     nxt = k_last ? WR_C : RD_A;
            WR_C:    if (mem_gnt_i) nxt = (i_last && j_last) ? DONE : RD_A;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            a_base  <= '0;
            b_base  <= '0;
            c_base  <= '0;
            m_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
        end else begin
            state   <= nxt;
            start_q <= start_i;
            if (launch) begin
                a_base <= matrix_a_addr_i;
                b_base <= matrix_b_addr_i;
                c_base <= matrix_c_addr_i;
                m_q    <= m_i;
                n_q    <= n_i;
                p_q    <= p_i;
                i      <= '0;
                j      <= '0;
                k      <= '0;
            end else if (state == MAC && !k_last) begin
                k <= k + 16'd1;
            end else if (wr_done) begin
                k <= '0;
                if (j_last) begin
                    j <= '0;
                    i <= i + 16'd1;
                end else begin
                    j <= j + 16'd1;
                end
            end
        end
    end

    // Address math is done at 32 bits and truncated, so bases wrap mod 2^AW.
    assign a_lin      = 32'(a_base) + 32'(i) * 32'(n_q) + 32'(k);
    assign b_lin      = 32'(b_base) + 32'(k) * 32'(p_q) + 32'(j);
    assign c_lin      = 32'(c_base) + 32'(i) * 32'(p_q) + 32'(j);
    assign unused_lin = ^{a_lin[31:AW], b_lin[31:AW], c_lin[31:AW]};

    always_comb begin
        mem_addr_o = '0;
        case (state)
            RD_A:    mem_addr_o = a_lin[AW-1:0];
            RD_B:    mem_addr_o = b_lin[AW-1:0];
            WR_C:    mem_addr_o = c_lin[AW-1:0];
            default: mem_addr_o = '0;
        endcase
    end

    assign mem_req_o   = (state == RD_A) || (state == RD_B) || (state == WR_C);
    assign mem_we_o    = (state == WR_C);
    assign mem_wdata_o = (state == WR_C) ? acc : '0;
    assign end_o       = (state == DONE);
    assign busy_o      = (state != IDLE);

    matmul_mac #(
        .DW(DW),
        .OW(OW)
    ) u_mac (
        .clk   (pclk),
        .rst   (preset),
        .clr   (launch || wr_done),
        .a_en  ((state == WAIT_A) && mem_rvalid_i),
        .b_en  ((state == WAIT_B) && mem_rvalid_i),
        .mac_en(state == MAC),
        .rdata (mem_rdata_i),
        .acc   (acc)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Randomized bench for matmul_ctrl: a memory model with optional stalls and a
// plain nested-loop matrix product as the reference for reads and C writes.
module tb_matmul_ctrl;

    logic        pclk = 1'b0;
    logic        preset;
    logic [15:0] cfg_a, cfg_b, cfg_c, cfg_m, cfg_n, cfg_p;
    logic        start;
    logic        done_p, busy, req, we, gnt, rvalid;
    logic [15:0] addr;
    logic [31:0] wdata, rdata;

    always #5 pclk = ~pclk;

    matmul_ctrl dut (
        .pclk           (pclk),
        .preset         (preset),
        .matrix_a_addr_i(cfg_a),
        .matrix_b_addr_i(cfg_b),
        .matrix_c_addr_i(cfg_c),
        .m_i            (cfg_m),
        .n_i            (cfg_n),
        .p_i            (cfg_p),
        .start_i        (start),
        .end_o          (done_p),
        .busy_o         (busy),
        .mem_req_o      (req),
        .mem_we_o       (we),
        .mem_addr_o     (addr),
        .mem_wdata_o    (wdata),
        .mem_gnt_i      (gnt),
        .mem_rvalid_i   (rvalid),
        .mem_rdata_i    (rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [0:65535];
    bit          stall = 0;
    int          rv_lat = 0;
    bit          pend = 0;
    int          pend_dly = 0;
    logic [31:0] pend_data;
    bit          hold_v = 0;
    logic [15:0] h_addr;
    logic        h_we;
    logic [31:0] h_wdata;
    logic [15:0] rd_q [$];
    logic [15:0] wr_a [$];
    logic [31:0] wr_d [$];

    initial begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
    end

    always @(negedge pclk) begin
        rvalid = 1'b0;
        rdata  = $urandom;
        if (pend) begin
            if (pend_dly == 0) begin
                rvalid = 1'b1;
                rdata  = pend_data;
                pend   = 0;
            end else begin
                pend_dly--;
            end
        end
        if (hold_v && req) begin
            chk("hold addr", addr, h_addr);
            chk("hold we", we, h_we);
            chk("hold wdata", wdata, h_wdata);
        end
        gnt    = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        hold_v = req && !gnt;
        h_addr = addr;
        h_we   = we;
        h_wdata = wdata;
        if (req && gnt) begin
            if (we) begin
                mem[addr] = wdata;
                wr_a.push_back(addr);
                wr_d.push_back(wdata);
            end else begin
                rd_q.push_back(addr);
                pend      = 1;
                pend_data = mem[addr];
                pend_dly  = stall ? $urandom_range(0, 3) : rv_lat;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] exp_rd [$];
    logic [15:0] exp_wa [$];
    logic [31:0] exp_wd [$];

    task automatic build_exp(input logic [15:0] ab, bb, cb, mm, nn, pp);
        logic [31:0] acc;
        logic [15:0] aa, ba;
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        if (mm == 0 || nn == 0 || pp == 0) return;
        for (int r = 0; r < int'(mm); r++)
            for (int c = 0; c < int'(pp); c++) begin
                acc = 0;
                for (int x = 0; x < int'(nn); x++) begin
                    aa = 16'(int'(ab) + r * int'(nn) + x);
                    ba = 16'(int'(bb) + x * int'(pp) + c);
                    exp_rd.push_back(aa);
                    exp_rd.push_back(ba);
                    acc += {16'h0, mem[aa][15:0]} * {16'h0, mem[ba][15:0]};
                end
                exp_wa.push_back(16'(int'(cb) + r * int'(pp) + c));
                exp_wd.push_back(acc);
            end
    endtask

    // exp_lat = 0 skips the latency check (stalled runs)
    task automatic run(input logic [15:0] ab, bb, cb, mm, nn, pp, input bit stl,
                       input int exp_lat, input string tag);
        int cnt, lat, ends, busy_n, post;
        build_exp(ab, bb, cb, mm, nn, pp);
        rd_q.delete();
        wr_a.delete();
        wr_d.delete();
        @(negedge pclk);
        stall = stl;
        cfg_a = ab; cfg_b = bb; cfg_c = cb;
        cfg_m = mm; cfg_n = nn; cfg_p = pp;
        start = 1'b1;
        cnt = 0; lat = 0; ends = 0; busy_n = 0; post = 0;
        while (post < 3 && cnt < 20000) begin
            @(negedge pclk);
            #1;
            cnt++;
            if (cnt == 3) begin
                // config churn while busy must not affect the run
                start = 1'b0;
                cfg_a = 16'($urandom); cfg_b = 16'($urandom); cfg_c = 16'($urandom);
                cfg_m = 16'($urandom_range(1, 4)); cfg_n = 16'($urandom_range(1, 4));
                cfg_p = 16'($urandom_range(1, 4));
            end
            if (done_p) begin
                ends++;
                if (lat == 0) lat = cnt;
            end
            if (busy) busy_n++;
            if (lat != 0 && cnt >= 4) post++;
        end
        stall = 0;
        chk({tag, " end seen"}, lat != 0, 1'b1);
        if (exp_lat > 0) chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " end pulses"}, ends, 1);
        chk({tag, " busy cycles"}, busy_n, lat);
        chk({tag, " read count"}, rd_q.size(), exp_rd.size());
        for (int x = 0; x < exp_rd.size() && x < rd_q.size(); x++)
            chk($sformatf("%s rd%0d addr", tag, x), rd_q[x], exp_rd[x]);
        chk({tag, " write count"}, wr_a.size(), exp_wa.size());
        for (int x = 0; x < exp_wa.size() && x < wr_a.size(); x++) begin
            chk($sformatf("%s wr%0d addr", tag, x), wr_a[x], exp_wa[x]);
            chk($sformatf("%s wr%0d data", tag, x), wr_d[x], exp_wd[x]);
        end
    endtask

    task automatic load_2x3x2();
        int av [6] = '{1, 2, 3, 4, 5, 6};
        int bv [6] = '{7, 8, 9, 10, 11, 12};
        for (int x = 0; x < 6; x++) begin
            mem[16'h0100 + 16'(x)] = 32'(av[x]);
            mem[16'h0200 + 16'(x)] = 32'(bv[x]);
        end
        for (int x = 0; x < 4; x++) mem[16'h0300 + 16'(x)] = '0;
    endtask

    task automatic chk_2x3x2(input string tag);
        chk({tag, " C00"}, mem[16'h0300], 32'd58);
        chk({tag, " C01"}, mem[16'h0301], 32'd64);
        chk({tag, " C10"}, mem[16'h0302], 32'd139);
        chk({tag, " C11"}, mem[16'h0303], 32'd154);
    endtask

    initial begin
        int ends, waited;
        logic [15:0] mm, nn, pp;
        bit stl;
        preset = 1'b1;
        start  = 1'b0;
        cfg_a = '0; cfg_b = '0; cfg_c = '0;
        cfg_m = '0; cfg_n = '0; cfg_p = '0;
        repeat (2) @(posedge pclk);
        #1;
        chk("reset req", req, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset end", done_p, 1'b0);
        chk("reset addr", addr, 16'h0);
        chk("reset wdata", wdata, 32'h0);
        @(negedge pclk);
        preset = 1'b0;
        repeat (2) @(negedge pclk);

        // 1x1x1
        mem[16'h0010] = 32'd3;
        mem[16'h0020] = 32'd4;
        mem[16'h0030] = 32'd0;
        run(16'h0010, 16'h0020, 16'h0030, 16'd1, 16'd1, 16'd1, 0, 7, "1x1x1");
        chk("1x1x1 C", mem[16'h0030], 32'd12);

        // 2x3x2, unstalled then stalled
        load_2x3x2();
        run(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd3, 16'd2, 0, 65, "2x3x2");
        chk_2x3x2("2x3x2");
        load_2x3x2();
        run(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd3, 16'd2, 1, 0, "2x3x2 stall");
        chk_2x3x2("2x3x2 stall");

        // zero inner dimension: no memory traffic, single DONE cycle
        run(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd0, 16'd2, 0, 1, "N0");

        // address wrap and accumulator wrap
        mem[16'hFFFE] = 32'h0000FFFF;
        mem[16'hFFFF] = 32'hABCDFFFF;
        mem[16'h0400] = 32'h0000FFFF;
        mem[16'h0401] = 32'h1234FFFF;
        mem[16'h0500] = '0;
        run(16'hFFFE, 16'h0400, 16'h0500, 16'd1, 16'd2, 16'd1, 0, 12, "wrap");
        if (rd_q.size() >= 3) begin
            chk("wrap rd0", rd_q[0], 16'hFFFE);
            chk("wrap rd2", rd_q[2], 16'hFFFF);
        end else begin
            chk("wrap reads", rd_q.size(), 4);
        end
        chk("wrap C", mem[16'h0500], 32'hFFFC0002);

        // reset while a B read is in flight; the stale response lands in IDLE
        load_2x3x2();
        rd_q.delete();
        rv_lat = 3;
        @(negedge pclk);
        cfg_a = 16'h0100; cfg_b = 16'h0200; cfg_c = 16'h0300;
        cfg_m = 16'd2; cfg_n = 16'd3; cfg_p = 16'd2;
        start = 1'b1;
        waited = 0;
        while (rd_q.size() < 2 && waited < 100) begin
            @(negedge pclk);
            #1;
            waited++;
        end
        chk("rst B read reached", rd_q.size() >= 2, 1'b1);
        @(posedge pclk);
        #2;
        preset = 1'b1;
        #1;
        chk("rst req drop", req, 1'b0);
        chk("rst busy drop", busy, 1'b0);
        chk("rst end", done_p, 1'b0);
        @(negedge pclk);
        start = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        ends = 0;
        repeat (6) begin
            @(negedge pclk);
            #1;
            if (done_p || busy || req) ends++;
        end
        chk("rst idle after stale rvalid", ends, 0);
        rv_lat = 0;
        run(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd3, 16'd2, 0, 65, "post-rst");
        chk_2x3x2("post-rst");

        // randomized shapes, data, bases and stalls
        for (int t = 0; t < 8; t++) begin
            logic [15:0] ab, bb, cb;
            mm  = 16'($urandom_range(1, 3));
            nn  = 16'($urandom_range(1, 3));
            pp  = 16'($urandom_range(1, 3));
            stl = bit'($urandom_range(0, 1));
            ab  = 16'h1000 + 16'($urandom_range(0, 16'h0FFF));
            bb  = 16'h3000 + 16'($urandom_range(0, 16'h0FFF));
            cb  = 16'h6000 + 16'($urandom_range(0, 16'h0FFF));
            for (int x = 0; x < 16; x++) begin
                mem[ab + 16'(x)] = $urandom;
                mem[bb + 16'(x)] = $urandom;
            end
            run(ab, bb, cb, mm, nn, pp, stl,
                stl ? 0 : int'(mm) * int'(pp) * (5 * int'(nn) + 1) + 1,
                $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
